// File: rtl/fp_mult_result_buffer.sv
// In-order result FIFO behind the non-stalling FP multiplier, with a credit counter that
// only lets the dispatcher issue when a slot is guaranteed for the result.
module fp_mult_result_buffer #(
  parameter int unsigned FP_WIDTH   = 32,
  parameter int unsigned TAG_WIDTH  = 1,
  parameter int unsigned STAT_WIDTH = 5,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  Issue_i,
  output logic                  Ready_o,
  input  logic                  UnitValid_i,
  input  logic [FP_WIDTH-1:0]   UnitRes_i,
  input  logic [TAG_WIDTH-1:0]  UnitTag_i,
  input  logic [STAT_WIDTH-1:0] UnitStatus_i,
  output logic                  Valid_o,
  output logic [FP_WIDTH-1:0]   Res_o,
  output logic [TAG_WIDTH-1:0]  Tag_o,
  output logic [STAT_WIDTH-1:0] Status_o,
  input  logic                  Ack_i,
  output logic                  Overflow_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned EntW = FP_WIDTH + TAG_WIDTH + STAT_WIDTH;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [EntW-1:0] mem_q [DEPTH];
  logic [EntW-1:0] mem_d [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] credits_q, credits_d;
  logic            overflow_q, overflow_d;

  logic full, push, pop, issue_acc;

  assign full      = (count_q == DepthCnt);
  assign push      = UnitValid_i && !full;
  assign pop       = (count_q != '0) && Ack_i;
  assign issue_acc = Issue_i && (credits_q != '0);

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    // A full buffer drops the push even if the head is popped this same cycle.
    if (UnitValid_i && full) begin
      overflow_d = 1'b1;
    end
    if (push) begin
      mem_d[wptr_q] = {UnitRes_i, UnitTag_i, UnitStatus_i};
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (issue_acc && !pop) begin
      credits_d = credits_q - CntW'(1);
    end else if (pop && !issue_acc && (credits_q != DepthCnt)) begin
      credits_d = credits_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      credits_q  <= DepthCnt;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
    end
  end

  assign Ready_o                    = (credits_q != '0);
  assign Valid_o                    = (count_q != '0);
  assign {Res_o, Tag_o, Status_o}   = mem_q[rptr_q];
  assign Overflow_o                 = overflow_q;

endmodule

// File: tb/tb_fp_mult_result_buffer.sv
// Bench for fp_mult_result_buffer: directed tables and sequences plus random traffic checked
// against a queue-based model of the buffer and its credit count.
module tb_fp_mult_result_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          Issue_i = 1'b0;
  logic          Ready_o;
  logic          UnitValid_i = 1'b0;
  logic [31:0]   UnitRes_i = '0;
  logic [TW-1:0] UnitTag_i = '0;
  logic [4:0]    UnitStatus_i = '0;
  logic          Valid_o;
  logic [31:0]   Res_o;
  logic [TW-1:0] Tag_o;
  logic [4:0]    Status_o;
  logic          Ack_i = 1'b0;
  logic          Overflow_o;

  fp_mult_result_buffer #(
    .FP_WIDTH  (32),
    .TAG_WIDTH (TW),
    .STAT_WIDTH(5),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .Issue_i     (Issue_i),
    .Ready_o     (Ready_o),
    .UnitValid_i (UnitValid_i),
    .UnitRes_i   (UnitRes_i),
    .UnitTag_i   (UnitTag_i),
    .UnitStatus_i(UnitStatus_i),
    .Valid_o     (Valid_o),
    .Res_o       (Res_o),
    .Tag_o       (Tag_o),
    .Status_o    (Status_o),
    .Ack_i       (Ack_i),
    .Overflow_o  (Overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0]   res;
    logic [TW-1:0] tag;
    logic [4:0]    st;
  } ent_t;

  ent_t q[$];
  int   credits = DEPTH;
  bit   ov      = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    credits = DEPTH;
    ov      = 1'b0;
  endtask

  task automatic compare_all();
    check("valid", Valid_o, q.size() != 0);
    check("ready", Ready_o, credits != 0);
    check("overflow", Overflow_o, ov);
    if (q.size() != 0) begin
      check("head_res", Res_o, q[0].res);
      check("head_tag", Tag_o, q[0].tag);
      check("head_status", Status_o, q[0].st);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cyc(input bit iss, input bit uv, input logic [31:0] r, input logic [TW-1:0] t,
                     input logic [4:0] s, input bit ack);
    bit pop, full, isd;
    ent_t e;
    Issue_i      = iss;
    UnitValid_i  = uv;
    UnitRes_i    = r;
    UnitTag_i    = t;
    UnitStatus_i = s;
    Ack_i        = ack;
    pop  = (q.size() != 0) && ack;
    full = (q.size() == DEPTH);
    isd  = iss && (credits != 0);
    if (pop) e = q.pop_front();
    if (uv) begin
      if (full) ov = 1'b1;
      else q.push_back('{res: r, tag: t, st: s});
    end
    credits = credits - int'(isd) + int'(pop);
    if (credits > DEPTH) credits = DEPTH;
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    Issue_i     = 1'b0;
    UnitValid_i = 1'b0;
    Ack_i       = 1'b0;
    rst_ni      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  typedef struct {
    bit            iss, uv, ack;
    logic [31:0]   res;
    logic [TW-1:0] tag;
    bit            ev, er;
    logic [31:0]   eres;
    logic [TW-1:0] etag;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int popped, issued, cycles;
    bit pend, tog, iss, ack;
    logic [TW-1:0] pend_tag;
    logic [31:0]   pend_res;

    // Reset values, during and after reset
    rst_ni = 1'b0;
    #12;
    check("rst_valid", Valid_o, 1'b0);
    check("rst_ready", Ready_o, 1'b1);
    check("rst_overflow", Overflow_o, 1'b0);
    check("rst_res", Res_o, 32'h0);
    check("rst_tag", Tag_o, 0);
    check("rst_status", Status_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    check("idle_res", Res_o, 32'h0);

    // Fill to credit exhaustion, then drain in order
    tbl[0] = '{1, 0, 0, 32'h0,        0, 0, 1, 32'h0,        0};
    tbl[1] = '{1, 1, 0, 32'h3F800000, 0, 1, 1, 32'h3F800000, 0};
    tbl[2] = '{1, 1, 0, 32'h40000000, 1, 1, 1, 32'h3F800000, 0};
    tbl[3] = '{1, 1, 0, 32'h40400000, 2, 1, 0, 32'h3F800000, 0};
    tbl[4] = '{1, 1, 0, 32'h40800000, 3, 1, 0, 32'h3F800000, 0};
    tbl[5] = '{0, 0, 0, 32'h0,        0, 1, 0, 32'h3F800000, 0};
    tbl[6] = '{0, 0, 1, 32'h0,        0, 1, 1, 32'h40000000, 1};
    tbl[7] = '{0, 0, 1, 32'h0,        0, 1, 1, 32'h40400000, 2};
    tbl[8] = '{0, 0, 1, 32'h0,        0, 1, 1, 32'h40800000, 3};
    tbl[9] = '{0, 0, 1, 32'h0,        0, 0, 1, 32'h0,        0};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].iss, tbl[i].uv, tbl[i].res, tbl[i].tag, 5'(tbl[i].tag) + 5'd1, tbl[i].ack);
      check($sformatf("tbl%0d_valid", i), Valid_o, tbl[i].ev);
      check($sformatf("tbl%0d_ready", i), Ready_o, tbl[i].er);
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_res", i), Res_o, tbl[i].eres);
        check($sformatf("tbl%0d_tag", i), Tag_o, tbl[i].etag);
      end
    end

    // Issue and pop together at credits==1
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h40A00000, 4, 5'd4, 0);
    cyc(1, 1, 32'h40C00000, 5, 5'd5, 0);
    cyc(0, 1, 32'h40E00000, 6, 5'd6, 0);
    check("pre_sim_ready", Ready_o, 1'b1);
    cyc(1, 0, 0, 0, 0, 1);
    check("sim_ready", Ready_o, 1'b1);
    check("sim_head_tag", Tag_o, 5);
    cyc(0, 1, 32'h41000000, 7, 5'd7, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) cyc(0, 0, 0, 0, 0, 1);
    check("sim_drained", Valid_o, 1'b0);

    // Overflow: five pushes bypassing credits
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 32'h3F800000 + 32'(i), TW'(i), 5'(i), 0);
      check($sformatf("ovf_push%0d", i), Overflow_o, i == 4);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_pop_tag%0d", i), Tag_o, i);
      cyc(0, 0, 0, 0, 0, 1);
    end
    check("ovf_empty", Valid_o, 1'b0);
    check("ovf_sticky", Overflow_o, 1'b1);

    // Wrap-around: ten results with Ack_i toggling
    apply_reset();
    popped = 0; issued = 0; cycles = 0; pend = 0; pend_tag = '0; tog = 1'b1;
    while (popped < 10 && cycles < 200) begin
      iss = (issued < 10) && (credits != 0);
      ack = tog;
      tog = !tog;
      if (ack && q.size() != 0) begin
        check("wrap_order", Tag_o, popped);
        popped++;
      end
      cyc(iss, pend, 32'h40000000 + 32'(pend_tag), pend_tag, 5'(pend_tag), ack);
      pend = iss;
      pend_tag = TW'(issued);
      if (iss) issued++;
      cycles++;
    end
    check("wrap_count", popped, 10);
    check("wrap_no_ovf", Overflow_o, 1'b0);

    // Asynchronous reset mid-stream
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h41100000, 4'hA, 5'd1, 0);
    cyc(0, 1, 32'h41200000, 4'hB, 5'd2, 0);
    check("mid_valid", Valid_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_valid", Valid_o, 1'b0);
    check("async_ready", Ready_o, 1'b1);
    check("async_ovf", Overflow_o, 1'b0);
    apply_reset();

    // Random legal traffic: results return one cycle after an accepted issue
    pend = 0;
    for (int i = 0; i < 1500; i++) begin
      iss = ($urandom_range(0, 3) != 0) && (credits != 0);
      pend_res = $urandom;
      cyc(iss || ($urandom_range(0, 7) == 0), pend, pend_res, TW'($urandom), 5'($urandom),
          $urandom_range(0, 1));
      pend = iss;
    end
    check("rand_legal_no_ovf", Overflow_o, 1'b0);

    // Random unconstrained traffic, including protocol violations
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom, TW'($urandom), 5'($urandom),
          $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mult_result_buffer.md
# fp_mult_result_buffer

Result buffer placed directly downstream of the FP multiplier wrapper inside the shared APU. The multiplier pipeline cannot stall and ignores its acknowledge, so this block absorbs every result in an in-order FIFO. It presents results to the interconnect with a valid/ack handshake. It also issues credits to the dispatcher, so an operation is only issued when a buffer slot is guaranteed for its result.

## Interface
- FP_WIDTH, 32, result width
- TAG_WIDTH, 1, tag width (must be ≥1)
- STAT_WIDTH, 5, status-flag width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- Issue_i  in  1  dispatcher starts an op in the multiplier this cycle
- Ready_o  out  1  credit available; issue accepted only when Issue_i && Ready_o
- UnitValid_i  in  1  multiplier result valid (multiplier Valid_o)
- UnitRes_i  in  FP_WIDTH  multiplier result
- UnitTag_i  in  TAG_WIDTH  multiplier tag
- UnitStatus_i  in  STAT_WIDTH  multiplier status flags
- Valid_o  out  1  head entry valid
- Res_o  out  FP_WIDTH  head result
- Tag_o  out  TAG_WIDTH  head tag
- Status_o  out  STAT_WIDTH  head status
- Ack_i  in  1  consumer takes head entry
- Overflow_o  out  1  sticky error: push attempted while full

## Operation
- Storage: DEPTH-entry array {res, tag, status}. Read/write pointers are clog2(DEPTH) bits and wrap naturally. Count is clog2(DEPTH+1) bits.
- Push: UnitValid_i=1 and count<DEPTH. The entry is written at wptr, wptr+1.
- Push when count==DEPTH: the entry is dropped and Overflow_o is set. This applies even if a pop happens in the same cycle. Overflow_o stays set until reset.
- Pop: Valid_o && Ack_i, rptr+1. Ack_i with Valid_o=0 is ignored.
- Simultaneous push and pop with 0<count<DEPTH: both happen and count is unchanged.
- Push and Ack_i at count==0: push only. No bypass, so Ack_i has no effect.
- Valid_o = (count!=0). Res_o, Tag_o and Status_o come combinationally from entry[rptr]. They are held stable while Valid_o=1 and Ack_i=0.
- Credit counter, clog2(DEPTH+1) bits, reset value DEPTH:
  - next = credits − (Issue_i && Ready_o) + pop
  - Both terms in the same cycle leave it unchanged.
  - Saturates at DEPTH (defensive only).
- Ready_o = (credits!=0), driven from the register. A pop in a credits==0 cycle raises Ready_o in the next cycle, not the same cycle.
- Issue_i while Ready_o=0 is ignored: no credit is consumed and no flag is raised.
- Invariant under legal use: credits + count + in-flight ops == DEPTH. Overflow is unreachable unless the dispatcher violates the protocol.
- Results are returned in issue order, since the multiplier is in-order.

## Timing
- Reset values: Valid_o=0, Ready_o=1, Overflow_o=0, Res_o/Tag_o/Status_o=0 (array cleared), pointers=0, count=0, credits=DEPTH.
- Push in cycle N → Valid_o=1 in cycle N+1. Buffer latency is 1 cycle.
- Pop in cycle N → next entry (or Valid_o=0) visible in cycle N+1.
- Sustained throughput is 1 result/cycle with Ack_i held high.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Buffered and in-flight results are lost. The dispatcher and multiplier are reset by the same rst_ni.

## Test plan
- Reset: hold rst_ni=0 → Valid_o=0, Ready_o=1, Overflow_o=0, Res_o=0x00000000; after release these stay the same with no stimulus.
- Fill to credit exhaustion (DEPTH=4, Ack_i=0):
  - Stimulus: 4 back-to-back Issue_i; results 0x3F800000, 0x40000000, 0x40400000, 0x40800000 with tags 0..3 return 1 cycle later.
  - Ready_o=0 from the cycle after the 4th issue. A 5th Issue_i is ignored and credits stay 0.
  - Valid_o=1 with Res_o=0x3F800000, Tag_o=0.
- Drain in order: with the buffer full, hold Ack_i=1 for 4 cycles.
  - Res_o steps 0x3F800000, 0x40000000, 0x40400000, 0x40800000, then Valid_o=0.
  - Ready_o returns to 1 the cycle after the first pop, and credits reach 4.
- Simultaneous issue+pop at credits==1: Issue_i=1 and Ack_i=1 in the same cycle → credits stays 1, Ready_o stays 1, count decrements.
- Overflow: force 5 UnitValid_i pushes with Ack_i=0, bypassing credits → 5th entry dropped, Overflow_o=1 and sticky. After draining, the popped tags are 0..3 only.
- Wrap-around: 10 results (tags 0..9) with Ack_i toggling 1/0 every cycle → tags emerge 0..9 in order and Overflow_o=0. Then assert rst_ni=0 mid-stream → Valid_o=0 and Ready_o=1 asynchronously.
